// File: rtl/sample_window_buffer.sv
// Sliding window over a serial IEEE754 sample stream; every hop samples the
// window is frozen onto a parallel bus and held until the downstream stage finishes.
module sample_window_buffer #(
   parameter int unsigned size = 28,
   parameter int unsigned hop  = 28,
   parameter int unsigned cntW = 8
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            clear,
   input  logic            sampleIn,
   input  logic [31:0]     sample,
   input  logic            resultReady,
   output logic [31:0]     data [0:size-1],
   output logic            frameValid,
   output logic            overrun,
   output logic [cntW-1:0] dropCount
);

   localparam int unsigned SAMPLE_W = 32;
   localparam int unsigned FILL_W   = $clog2(size + 1);
   localparam int unsigned HOP_W    = (hop > 1) ? $clog2(hop) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [SAMPLE_W-1:0] r_win      [0:size-1];
   logic [SAMPLE_W-1:0] w_win_next [0:size-1];
   logic [SAMPLE_W-1:0] r_data     [0:size-1];

   logic [FILL_W-1:0] r_fill;
   logic [FILL_W-1:0] w_fill_next;
   logic [HOP_W-1:0]  r_hop_cnt;
   logic [HOP_W-1:0]  w_hop_next;
   logic              w_trigger;

   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic              r_frame_valid;
   logic              w_frame_valid_next;
   logic              r_overrun;
   logic              w_overrun_next;
   logic [cntW-1:0]   r_drop_cnt;
   logic [cntW-1:0]   w_drop_cnt_next;
   logic              w_load;

   // Window after shifting in the current sample; snapshots always take this view.
   always_comb begin
      for (int unsigned i = 0; i < size - 1; i++) begin
         w_win_next[i] = r_win[i + 1];
      end
      w_win_next[size-1] = sample;
   end

   // Fill and hop tracking: first trigger when the window fills, then every hop-th sample.
   always_comb begin
      w_fill_next = r_fill;
      w_hop_next  = r_hop_cnt;
      w_trigger   = 1'b0;
      if (clear) begin
         w_fill_next = '0;
         w_hop_next  = '0;
      end else if (sampleIn) begin
         if (r_fill == FILL_W'(size)) begin
            if (r_hop_cnt == HOP_W'(hop - 1)) begin
               w_hop_next = '0;
               w_trigger  = 1'b1;
            end else begin
               w_hop_next = r_hop_cnt + HOP_W'(1);
            end
         end else begin
            w_fill_next = r_fill + FILL_W'(1);
            if (r_fill == FILL_W'(size - 1)) begin
               w_trigger  = 1'b1;
               w_hop_next = '0;
            end
         end
      end
   end

   // Frame handshake: publish, hold until resultReady, then force one low cycle.
   always_comb begin
      w_state_next       = r_state;
      w_frame_valid_next = r_frame_valid;
      w_overrun_next     = r_overrun;
      w_drop_cnt_next    = r_drop_cnt;
      w_load             = 1'b0;
      if (clear) begin
         w_state_next       = S_IDLE;
         w_frame_valid_next = 1'b0;
         w_overrun_next     = 1'b0;
         w_drop_cnt_next    = '0;
      end else begin
         case (r_state)
            S_IDLE, S_GAP: begin
               w_state_next = S_IDLE;
               if (w_trigger) begin
                  w_load             = 1'b1;
                  w_frame_valid_next = 1'b1;
                  w_state_next       = S_BUSY;
               end
            end
            S_BUSY: begin
               if (w_trigger) begin
                  w_overrun_next = 1'b1;
                  if (r_drop_cnt != {cntW{1'b1}}) begin
                     w_drop_cnt_next = r_drop_cnt + cntW'(1);
                  end
               end
               if (resultReady) begin
                  w_frame_valid_next = 1'b0;
                  w_state_next       = S_GAP;
               end
            end
            default: begin
               w_state_next       = S_IDLE;
               w_frame_valid_next = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state       <= S_IDLE;
         r_frame_valid <= 1'b0;
         r_overrun     <= 1'b0;
         r_drop_cnt    <= '0;
         r_fill        <= '0;
         r_hop_cnt     <= '0;
      end else begin
         r_state       <= w_state_next;
         r_frame_valid <= w_frame_valid_next;
         r_overrun     <= w_overrun_next;
         r_drop_cnt    <= w_drop_cnt_next;
         r_fill        <= w_fill_next;
         r_hop_cnt     <= w_hop_next;
      end
   end

   // Window shifts on every accepted sample regardless of the handshake state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < size; i++) begin
            r_win[i] <= '0;
         end
      end else if (sampleIn && !clear) begin
         for (int unsigned i = 0; i < size; i++) begin
            r_win[i] <= w_win_next[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < size; i++) begin
            r_data[i] <= '0;
         end
      end else if (w_load) begin
         for (int unsigned i = 0; i < size; i++) begin
            r_data[i] <= w_win_next[i];
         end
      end
   end

   assign data       = r_data;
   assign frameValid = r_frame_valid;
   assign overrun    = r_overrun;
   assign dropCount  = r_drop_cnt;

endmodule
